// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART serialiser, with a launch FSM
// that pops one byte at a time. The FSM waits for the serialiser to report
// busy, and then for it to report done, before it launches the next byte.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   wr_en      host write strobe
//   wr_data    host byte to enqueue
//   full       registered, count == DEPTH
//   empty      registered, count == 0
//   count      registered number of stored bytes
//   overflow   one-cycle pulse after a dropped write
//   tx_start   one-cycle launch pulse to the serialiser
//   tx_data    launched byte, held until the next launch
//   tx_active  serialiser busy flag
//   tx_err     one-cycle pulse when the serialiser never went busy
module uart_tx_fifo #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned BUSY_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     tx_start,
   output logic [7:0]               tx_data,
   input  logic                     tx_active,
   output logic                     tx_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   // Timer counts 0..BUSY_TIMEOUT-1 while waiting for tx_active.
   localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count_nxt;
   logic            pop_c;
   logic            push_c;

   // A pop happens only on the launch edge. A write to a full FIFO is
   // accepted when it coincides with that pop.
   assign pop_c  = (state == IDLE) && !empty && !tx_active;
   assign push_c = wr_en && (!full || pop_c);

   // Next occupancy; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt = count;
      if (push_c && !pop_c) begin
         count_nxt = count + CW'(1);
      end else if (!push_c && pop_c) begin
         count_nxt = count - CW'(1);
      end
   end

   // Storage. On a push and pop at full, both pointers address the same
   // slot; the launch reads the old byte because the write is non-blocking.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and registered status flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         // Power-of-two depth makes the pointers wrap naturally.
         if (push_c) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count    <= count_nxt;
         full     <= (count_nxt == CW'(DEPTH));
         empty    <= (count_nxt == '0);
         overflow <= wr_en && !push_c;
      end
   end

   // Launch FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         timer    <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
         tx_err   <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         tx_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (pop_c) begin
                  tx_data  <= mem[rd_ptr];
                  tx_start <= 1'b1;
                  timer    <= '0;
                  state    <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (tx_active) begin
                  state <= WAIT_DONE;
               end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                  // Serialiser never responded; the popped byte is dropped.
                  tx_err <= 1'b1;
                  state  <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_active) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scenarios plus randomized traffic for
// uart_tx_fifo. A queue-based reference model is compared with the DUT on
// every falling edge. A small serialiser agent drives tx_active.
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned BT    = 4;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   localparam int P_IDLE = 0;
   localparam int P_BUSY = 1;
   localparam int P_DONE = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [7:0]    wr_data = 8'h00;
   logic          tx_active = 1'b0;
   logic          full, empty, overflow, tx_start, tx_err;
   logic [CW-1:0] count;
   logic [7:0]    tx_data;

   uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_active (tx_active),
      .tx_err    (tx_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   logic [7:0] mq[$];
   int         m_phase = P_IDLE;
   int         m_wait  = 0;
   logic       m_tx_start = 1'b0;
   logic       m_tx_err = 1'b0;
   logic       m_ovf = 1'b0;
   logic [7:0] m_tx_data = 8'h00;
   logic       m_pop, m_push;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_phase    = P_IDLE;
         m_wait     = 0;
         m_tx_start = 1'b0;
         m_tx_err   = 1'b0;
         m_ovf      = 1'b0;
         m_tx_data  = 8'h00;
      end else begin
         m_pop  = (m_phase == P_IDLE) && (mq.size() > 0) && !tx_active;
         m_push = wr_en && ((mq.size() < DEPTH) || m_pop);
         m_ovf  = wr_en && !m_push;
         m_tx_start = m_pop;
         m_tx_err   = 1'b0;
         if (m_phase == P_IDLE) begin
            if (m_pop) begin
               m_tx_data = mq.pop_front();
               m_phase   = P_BUSY;
               m_wait    = 0;
            end
         end else if (m_phase == P_BUSY) begin
            if (tx_active) begin
               m_phase = P_DONE;
            end else begin
               m_wait++;
               if (m_wait >= BT) begin
                  m_tx_err = 1'b1;
                  m_phase  = P_IDLE;
               end
            end
         end else begin
            if (!tx_active) m_phase = P_IDLE;
         end
         if (m_push) mq.push_back(wr_data);
      end
   end

   // ---------------- compare process ----------------
   logic [7:0] tx_log[$];
   int         n_ovf = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",    32'(count),    32'(mq.size()));
         chk("empty",    32'(empty),    32'(mq.size() == 0));
         chk("full",     32'(full),     32'(mq.size() == DEPTH));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("tx_start", 32'(tx_start), 32'(m_tx_start));
         chk("tx_err",   32'(tx_err),   32'(m_tx_err));
         chk("tx_data",  32'(tx_data),  32'(m_tx_data));
         if (tx_start === 1'b1) tx_log.push_back(tx_data);
         if (overflow === 1'b1) n_ovf++;
      end
   end

   // ---------------- serialiser agent ----------------
   // mode 0: responds to tx_start; 1: stuck low; 2: stuck high
   int ser_mode  = 0;
   int ser_frame = 0;
   int ser_drop  = 0;
   int ser_dly   = -1;
   int ser_len   = 0;
   int ser_left  = 0;

   always @(posedge clk) begin
      #1;
      if (!reset) begin
         tx_active = 1'b0;
         ser_dly   = -1;
      end else if (ser_mode == 1) begin
         tx_active = 1'b0;
      end else if (ser_mode == 2) begin
         tx_active = 1'b1;
      end else begin
         if (tx_active) begin
            ser_left--;
            if (ser_left <= 0) tx_active = 1'b0;
         end
         if (tx_start === 1'b1 && ($urandom_range(0, 99) >= ser_drop)) begin
            ser_dly = $urandom_range(0, 2);
            ser_len = (ser_frame > 0) ? ser_frame : $urandom_range(1, 8);
         end
         if (ser_dly == 0) begin
            tx_active = 1'b1;
            ser_left  = ser_len;
            ser_dly   = -1;
         end else if (ser_dly > 0) begin
            ser_dly--;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_idle(input int max_cyc);
      int i;
      i = 0;
      while (i < max_cyc) begin
         @(negedge clk);
         if (empty && !tx_active && m_phase == P_IDLE) break;
         i++;
      end
      chk("drain_done", 32'(i < max_cyc), 32'd1);
   endtask

   task automatic count_starts(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (tx_start) n++;
      end
   endtask

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   int n_st;
   int ovf0;
   int err_at;
   int n_err;
   int wr_pct;
   int wguard;

   initial begin
      #1 reset = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'h00);
      chk("rst_tx_err", 32'(tx_err), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b1;
      ser_mode = 0; ser_frame = 160; ser_drop = 0;
      @(negedge clk);

      // single byte, long frame
      wr_en = 1'b1; wr_data = 8'hA5;
      @(negedge clk);
      wr_en = 1'b0; wr_data = 8'h77;
      chk("single_empty_after_E", 32'(empty), 32'd0);
      chk("single_count_after_E", 32'(count), 32'd1);
      chk("single_no_start_yet", 32'(tx_start), 32'd0);
      @(negedge clk);
      chk("single_tx_start", 32'(tx_start), 32'd1);
      chk("single_tx_data", 32'(tx_data), 32'hA5);
      chk("model_tx_data_pin", 32'(m_tx_data), 32'hA5);
      count_starts(250, n_st);
      chk("single_extra_starts", 32'(n_st), 32'd0);
      wait_idle(400);
      ser_frame = 0;

      // ordering and pointer wrap while draining
      tx_log.delete();
      ovf0 = n_ovf;
      for (int i = 0; i < 20; i++) begin
         wguard = 0;
         while (full && wguard < 500) begin
            @(negedge clk);
            wguard++;
         end
         wr_en = 1'b1; wr_data = 8'(i);
         @(negedge clk);
         wr_en = 1'b0; wr_data = 8'($urandom);
         repeat (2) @(negedge clk);
      end
      wait_idle(2000);
      chk("order_len", 32'(tx_log.size()), 32'd20);
      for (int i = 0; i < 20 && i < tx_log.size(); i++)
         chk("order_byte", 32'(tx_log[i]), 32'(i));
      chk("order_no_overflow", 32'(n_ovf - ovf0), 32'd0);

      // full and overflow with the serialiser held busy
      ser_mode = 2;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h40 + i);
         @(negedge clk);
         if (i == 15) begin
            chk("fill_full", 32'(full), 32'd1);
            chk("fill_count", 32'(count), 32'd16);
            chk("fill_no_ovf", 32'(overflow), 32'd0);
         end
         if (i == 16) begin
            chk("ovf_pulse", 32'(overflow), 32'd1);
            chk("ovf_count", 32'(count), 32'd16);
            chk("model_count_pin", 32'(mq.size()), 32'd16);
         end
      end
      wr_en = 1'b0;
      ser_mode = 0;
      tx_log.delete();
      @(negedge clk);
      chk("ovf_one_cycle", 32'(overflow), 32'd0);
      chk("still_full", 32'(full), 32'd1);

      // push on the same edge as the launch pop at full
      wr_en = 1'b1; wr_data = 8'h5A;
      @(negedge clk);
      wr_en = 1'b0;
      chk("pushpop_count", 32'(count), 32'd16);
      chk("pushpop_no_ovf", 32'(overflow), 32'd0);
      chk("pushpop_start", 32'(tx_start), 32'd1);
      chk("pushpop_data", 32'(tx_data), 32'h40);
      wait_idle(2000);
      chk("full_log_len", 32'(tx_log.size()), 32'd17);
      for (int i = 0; i < 16 && i < tx_log.size(); i++)
         chk("full_log_byte", 32'(tx_log[i]), 32'(8'h40 + i));
      if (tx_log.size() == 17) chk("last_is_5a", 32'(tx_log[16]), 32'h5A);

      // launch timeout
      ser_mode = 1;
      wr_en = 1'b1; wr_data = 8'h3C;
      @(negedge clk);
      wr_en = 1'b0;
      @(negedge clk);
      chk("to_start", 32'(tx_start), 32'd1);
      chk("to_data", 32'(tx_data), 32'h3C);
      err_at = 0; n_err = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (tx_err) begin
            n_err++;
            if (err_at == 0) err_at = k;
         end
      end
      chk("to_err_delay", 32'(err_at), 32'(BT));
      chk("to_err_once", 32'(n_err), 32'd1);
      chk("to_empty", 32'(empty), 32'd1);
      ser_mode = 0;

      // reset during WAIT_DONE
      ser_frame = 20;
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      wguard = 0;
      while (!tx_active && wguard < 30) begin
         @(negedge clk);
         wguard++;
      end
      chk("rmf_active_seen", 32'(tx_active), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rmf_count", 32'(count), 32'd0);
      chk("rmf_empty", 32'(empty), 32'd1);
      chk("rmf_full", 32'(full), 32'd0);
      chk("rmf_tx_start", 32'(tx_start), 32'd0);
      chk("rmf_tx_data", 32'(tx_data), 32'h00);
      chk("rmf_tx_err", 32'(tx_err), 32'd0);
      chk("rmf_overflow", 32'(overflow), 32'd0);
      count_starts(3, n_st);
      chk("rmf_no_start_in_reset", 32'(n_st), 32'd0);
      reset = 1'b1;
      count_starts(40, n_st);
      chk("rmf_no_start_after", 32'(n_st), 32'd0);
      ser_frame = 0;

      // randomized traffic
      for (int s = 0; s < 15; s++) begin
         case ($urandom_range(0, 2))
            0: wr_pct = 10;
            1: wr_pct = 40;
            default: wr_pct = 90;
         endcase
         case ($urandom_range(0, 4))
            0: ser_mode = 2;
            1: ser_mode = 1;
            default: ser_mode = 0;
         endcase
         ser_drop = 10 * $urandom_range(0, 2);
         repeat (200) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 99) < wr_pct);
            wr_data = 8'($urandom);
         end
      end
      @(negedge clk);
      wr_en = 1'b0;
      ser_mode = 0; ser_drop = 0;
      wait_idle(3000);
      chk("end_model_empty", 32'(mq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
